frame_commit_ctrl: RTL and testbench

//  Frame-synchronous update scheduler for the screen mux path. PicoBlaze writes new

---
 rtl/frame_commit_pkg.sv | 29 ++
 rtl/frame_blink_gen.sv | 27 ++
 rtl/frame_commit_ctrl.sv | 132 +++++++++++++
 tb/tb_frame_commit_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/frame_commit_pkg.sv
// rtl/frame_commit_pkg.sv - shared field addresses, FSM encoding and BCD check for frame_commit_ctrl
package frame_commit_pkg;

    localparam logic [3:0] A_HOUR_H  = 4'd0;
    localparam logic [3:0] A_HOUR_M  = 4'd1;
    localparam logic [3:0] A_HOUR_S  = 4'd2;
    localparam logic [3:0] A_DATE_D  = 4'd3;
    localparam logic [3:0] A_DATE_M  = 4'd4;
    localparam logic [3:0] A_DATE_Y  = 4'd5;
    localparam logic [3:0] A_TIMER_H = 4'd6;
    localparam logic [3:0] A_TIMER_M = 4'd7;
    localparam logic [3:0] A_TIMER_S = 4'd8;
    localparam logic [3:0] A_CURSOR  = 4'd9;
    localparam logic [3:0] A_RING    = 4'd10;

    localparam int         NUM_FIELDS  = 9;
    localparam logic [3:0] CURSOR_NONE = 4'hF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    function automatic logic bcd_ok(input logic [7:0] d);
        return (d[7:4] <= 4'd9) && (d[3:0] <= 4'd9);
    endfunction

endpackage

// File: rtl/frame_blink_gen.sv
// rtl/frame_blink_gen.sv - frame-counted blink phase, toggles every BLINK_FRAMES vertical blanks
module frame_blink_gen #(
    parameter int BLINK_FRAMES = 30
) (
    input  logic clk,
    input  logic reset,
    input  logic vb_rise,
    output logic phase_on
);

    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count    <= 8'd0;
            phase_on <= 1'b1;
        end else if (vb_rise) begin
            if (count == 8'(BLINK_FRAMES - 1)) begin
                count    <= 8'd0;
                phase_on <= ~phase_on;
            end else begin
                count <= count + 8'd1;
            end
        end
    end

endmodule

// File: rtl/frame_commit_ctrl.sv
// rtl/frame_commit_ctrl.sv - stages display writes and commits them atomically at vertical-blank entry
module frame_commit_ctrl #(
    parameter int V_ACTIVE     = 480,
    parameter int BLINK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  pix_y,
    input  logic        wr_strobe,
    input  logic [3:0]  wr_addr,
    input  logic [7:0]  wr_data,
    output logic [23:0] hora_bcd,
    output logic [23:0] fecha_bcd,
    output logic [23:0] timer_bcd,
    output logic [8:0]  field_blank,
    output logic        ring_vis,
    output logic        pending,
    output logic        wr_err,
    output logic        commit_pulse
);
    import frame_commit_pkg::*;

    logic       vblank, vblank_q, vb_rise;
    logic       wr_ok, do_commit, phase_on;
    state_t     state, state_next;
    logic [7:0] stage_bcd [NUM_FIELDS];
    logic [7:0] com_bcd   [NUM_FIELDS];
    logic [3:0] stage_cursor, com_cursor;
    logic       stage_ring, com_ring;

    always_ff @(posedge clk) begin
        if (!reset) begin
            vblank   <= 1'b0;
            vblank_q <= 1'b0;
        end else begin
            vblank   <= (pix_y >= 10'(V_ACTIVE));
            vblank_q <= vblank;
        end
    end

    assign vb_rise = vblank & ~vblank_q;

    always_comb begin
        wr_ok = 1'b0;
        if (wr_strobe) begin
            if (wr_addr <= A_TIMER_S)
                wr_ok = bcd_ok(wr_data);
            else if (wr_addr == A_CURSOR || wr_addr == A_RING)
                wr_ok = 1'b1;
        end
    end

    // A write landing on the commit edge goes to staging only, so it waits for the next frame.
    assign do_commit = (state == PENDING) && vb_rise;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            pending <= 1'b0;
            wr_err  <= 1'b0;
        end else begin
            state <= state_next;
            if (wr_ok)
                pending <= 1'b1;
            else if (do_commit)
                pending <= 1'b0;
            if (wr_strobe && !wr_ok)
                wr_err <= 1'b1;
        end
    end

    always_comb begin
        state_next   = state;
        commit_pulse = 1'b0;
        case (state)
            IDLE:    if (wr_ok) state_next = PENDING;
            PENDING: if (vb_rise) state_next = COMMIT;
            COMMIT: begin
                commit_pulse = 1'b1;
                state_next   = (pending || wr_ok) ? PENDING : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_FIELDS; i++) begin
                stage_bcd[i] <= 8'd0;
                com_bcd[i]   <= 8'd0;
            end
            stage_cursor <= CURSOR_NONE;
            com_cursor   <= CURSOR_NONE;
            stage_ring   <= 1'b0;
            com_ring     <= 1'b0;
        end else begin
            if (do_commit) begin
                for (int i = 0; i < NUM_FIELDS; i++)
                    com_bcd[i] <= stage_bcd[i];
                com_cursor <= stage_cursor;
                com_ring   <= stage_ring;
            end
            if (wr_ok) begin
                if (wr_addr <= A_TIMER_S)
                    stage_bcd[wr_addr] <= wr_data;
                else if (wr_addr == A_CURSOR)
                    stage_cursor <= wr_data[3:0];
                else
                    stage_ring <= wr_data[0];
            end
        end
    end

    frame_blink_gen #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
        .clk      (clk),
        .reset    (reset),
        .vb_rise  (vb_rise),
        .phase_on (phase_on)
    );

    assign hora_bcd  = {com_bcd[A_HOUR_H],  com_bcd[A_HOUR_M],  com_bcd[A_HOUR_S]};
    assign fecha_bcd = {com_bcd[A_DATE_D],  com_bcd[A_DATE_M],  com_bcd[A_DATE_Y]};
    assign timer_bcd = {com_bcd[A_TIMER_H], com_bcd[A_TIMER_M], com_bcd[A_TIMER_S]};
    assign ring_vis  = com_ring & phase_on;

    always_comb begin
        field_blank = 9'd0;
        for (int i = 0; i < NUM_FIELDS; i++)
            field_blank[i] = ~phase_on && (com_cursor == 4'(i));
    end

endmodule

// File: tb/tb_frame_commit_ctrl.sv
// tb/tb_frame_commit_ctrl.sv - randomized and directed bench with a frame-level reference model
module tb_frame_commit_ctrl;

    localparam int BF = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  pix_y;
    logic        wr_strobe;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [23:0] hora_bcd, fecha_bcd, timer_bcd;
    logic [8:0]  field_blank;
    logic        ring_vis, pending, wr_err, commit_pulse;

    frame_commit_ctrl #(.V_ACTIVE(480), .BLINK_FRAMES(BF)) dut (
        .clk          (clk),
        .reset        (reset),
        .pix_y        (pix_y),
        .wr_strobe    (wr_strobe),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .hora_bcd     (hora_bcd),
        .fecha_bcd    (fecha_bcd),
        .timer_bcd    (timer_bcd),
        .field_blank  (field_blank),
        .ring_vis     (ring_vis),
        .pending      (pending),
        .wr_err       (wr_err),
        .commit_pulse (commit_pulse)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] m_stage [9];
    logic [7:0] m_com   [9];
    logic [3:0] m_cur_s, m_cur_c;
    logic       m_ring_s, m_ring_c;
    logic       m_pend, m_err, m_pulse, m_vb1, m_vb2, m_off;
    int         m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input bit rst, input int py, input bit stb, input int addr, input int data);
        bit rise, ok, commit;
        if (!rst) begin
            for (int i = 0; i < 9; i++) begin
                m_stage[i] = 8'd0;
                m_com[i]   = 8'd0;
            end
            m_cur_s = 4'hF; m_cur_c = 4'hF;
            m_ring_s = 0; m_ring_c = 0;
            m_pend = 0; m_err = 0; m_pulse = 0;
            m_vb1 = 0; m_vb2 = 0; m_off = 0; m_cnt = 0;
        end else begin
            rise   = m_vb1 && !m_vb2;
            ok     = stb && ((addr <= 8 && (data / 16) < 10 && (data % 16) < 10) || addr == 9 || addr == 10);
            commit = m_pend && rise;
            m_pulse = commit;
            if (commit) begin
                m_com    = m_stage;
                m_cur_c  = m_cur_s;
                m_ring_c = m_ring_s;
            end
            if (ok) begin
                m_pend = 1;
                if (addr <= 8)       m_stage[addr] = 8'(data);
                else if (addr == 9)  m_cur_s = 4'(data % 16);
                else                 m_ring_s = (data % 2) == 1;
            end else if (commit) begin
                m_pend = 0;
            end
            if (stb && !ok) m_err = 1;
            if (rise) begin
                m_cnt = (m_cnt + 1) % BF;
                if (m_cnt == 0) m_off = !m_off;
            end
            m_vb2 = m_vb1;
            m_vb1 = (py >= 480);
        end
    endtask

    task automatic compare_all();
        logic [8:0] exp_fb;
        exp_fb = (m_off && m_cur_c < 4'd9) ? 9'(1 << m_cur_c) : 9'd0;
        check("hora",         hora_bcd,     {m_com[0], m_com[1], m_com[2]});
        check("fecha",        fecha_bcd,    {m_com[3], m_com[4], m_com[5]});
        check("timer",        timer_bcd,    {m_com[6], m_com[7], m_com[8]});
        check("field_blank",  field_blank,  exp_fb);
        check("ring_vis",     ring_vis,     m_ring_c && !m_off);
        check("pending",      pending,      m_pend);
        check("wr_err",       wr_err,       m_err);
        check("commit_pulse", commit_pulse, m_pulse);
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input bit rst, input int py, input bit stb, input int addr, input int data);
        reset     = rst;
        pix_y     = 10'(py);
        wr_strobe = stb;
        wr_addr   = 4'(addr);
        wr_data   = 8'(data);
        @(posedge clk);
        model_edge(rst, py, stb, addr, data);
        @(negedge clk);
        compare_all();
    endtask

    task automatic frame();
        for (int i = 0; i < 3; i++) step(1, 100, 0, 0, 0);
        step(1, 480, 0, 0, 0);
        step(1, 480, 0, 0, 0);
    endtask

    int py;

    initial begin
        reset = 0; pix_y = 0; wr_strobe = 0; wr_addr = 0; wr_data = 0;
        @(negedge clk);

        for (int i = 0; i < 3; i++) step(0, 100, 1, 0, 8'h12);
        check("rst_hora", hora_bcd, 24'h0);
        check("rst_pend", pending, 1'b0);
        check("rst_err",  wr_err, 1'b0);

        step(1, 100, 1, 0, 8'h12);
        check("wr_pend", pending, 1'b1);
        step(1, 100, 0, 0, 0);
        step(1, 480, 0, 0, 0);
        check("pre_commit_hora", hora_bcd, 24'h0);
        step(1, 480, 0, 0, 0);
        check("commit_hora",  hora_bcd, 24'h120000);
        check("commit_pulse", commit_pulse, 1'b1);
        check("commit_pend",  pending, 1'b0);
        step(1, 480, 0, 0, 0);
        check("pulse_one_cycle", commit_pulse, 1'b0);

        step(1, 480, 1, 4, 8'h1A);
        check("err_bcd", wr_err, 1'b1);
        check("err_pend", pending, 1'b0);
        step(1, 480, 1, 12, 8'h00);
        check("err_addr_pend", pending, 1'b0);

        step(1, 100, 1, 0, 8'h23);
        step(1, 100, 0, 0, 0);
        step(1, 480, 0, 0, 0);
        step(1, 480, 1, 6, 8'h05);
        check("rise_wr_hora",  hora_bcd, 24'h230000);
        check("rise_wr_timer", timer_bcd, 24'h0);
        check("rise_wr_pend",  pending, 1'b1);
        step(1, 480, 1, 7, 8'h11);
        check("commit_wr_pend", pending, 1'b1);
        frame();
        check("next_frame_timer", timer_bcd, 24'h051100);

        step(1, 100, 1, 9, 3);
        step(1, 100, 1, 10, 1);
        for (int f = 0; f < 8; f++) begin
            frame();
            check("blink_fb", (field_blank == 9'h008 || field_blank == 9'h000), 1'b1);
            check("blink_ring", ring_vis, !field_blank[3]);
        end
        step(1, 100, 1, 9, 9);
        for (int f = 0; f < 4; f++) begin
            frame();
            check("cursor_none", field_blank, 9'h0);
        end

        step(1, 100, 1, 1, 8'h45);
        step(0, 100, 0, 0, 0);
        step(1, 100, 0, 0, 0);
        step(1, 480, 0, 0, 0);
        step(1, 480, 0, 0, 0);
        check("rst_drop_pulse", commit_pulse, 1'b0);
        check("rst_drop_hora",  hora_bcd, 24'h0);

        py = 0;
        for (int c = 0; c < 6000; c++) begin
            bit rst_n, stb;
            int addr, data;
            py = py + int'($urandom_range(0, 40));
            if (py >= 525) py = py - 525;
            if ($urandom_range(0, 199) == 0) py = int'($urandom_range(0, 1023));
            rst_n = ($urandom_range(0, 399) != 0);
            stb   = ($urandom_range(0, 5) == 0);
            addr  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 10));
            data  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 255))
                                                : int'($urandom_range(0, 9) * 16 + $urandom_range(0, 9));
            step(rst_n, py, stb, addr, data);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
